// File: rtl/riscv_div_unit_if.sv
// Start/done handshake bundle between the ALU (master) and the iterative divider (slave).
interface riscv_div_unit_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            start;
   logic [2:0]      fun3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, fun3, op_a, op_b,
      input  busy, done, result
   );

   modport slave (
      input  start, fun3, op_a, op_b,
      output busy, done, result
   );
endinterface

// File: rtl/riscv_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle; divide-by-zero and signed overflow finish in the accept cycle.
module riscv_div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   riscv_div_unit_if.slave bus
);
   localparam int unsigned CntW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StOut} state_e;

   state_e          r_state;
   logic            r_busy;
   logic            r_done;
   logic [XLEN-1:0] r_result;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_div;
   logic [CntW-1:0] r_cnt;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_is_rem;

   logic            w_accept;
   logic            w_signed;
   logic            w_is_rem;
   logic            w_div_zero;
   logic            w_ovf;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic [XLEN-1:0] w_special;
   logic [XLEN:0]   w_shift;
   logic            w_ge;
   logic [XLEN-1:0] w_sub;
   logic [XLEN-1:0] w_quo_fix;
   logic [XLEN-1:0] w_rem_fix;

   always_comb begin
      w_accept   = bus.start && bus.fun3[2] && (r_state == StIdle || r_state == StOut);
      w_signed   = !bus.fun3[0];
      w_is_rem   = bus.fun3[1];
      w_div_zero = (bus.op_b == '0);
      w_ovf      = w_signed && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
      w_abs_a    = (w_signed && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
      w_abs_b    = (w_signed && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
      w_special  = w_div_zero ? (w_is_rem ? bus.op_a : '1) : (w_is_rem ? '0 : bus.op_a);
      // Partial remainder plus next dividend bit; compare is XLEN+1 bits wide.
      w_shift    = {r_rem, r_quo[XLEN-1]};
      w_ge       = (w_shift >= {1'b0, r_div});
      w_sub      = w_shift[XLEN-1:0] - r_div;
      w_quo_fix  = r_neg_q ? -r_quo : r_quo;
      w_rem_fix  = r_neg_r ? -r_rem : r_rem;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= StIdle;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_rem <= 1'b0;
      end else begin
         case (r_state)
            StIdle, StOut: begin
               r_done  <= 1'b0;
               r_state <= StIdle;
               if (w_accept) begin
                  if (w_div_zero || w_ovf) begin
                     r_result <= w_special;
                     r_done   <= 1'b1;
                     r_state  <= StOut;
                  end else begin
                     r_rem    <= '0;
                     r_quo    <= w_abs_a;
                     r_div    <= w_abs_b;
                     r_cnt    <= CntW'(XLEN - 1);
                     r_neg_q  <= w_signed && (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
                     r_neg_r  <= w_signed && bus.op_a[XLEN-1];
                     r_is_rem <= w_is_rem;
                     r_busy   <= 1'b1;
                     r_state  <= StCalc;
                  end
               end
            end
            StCalc: begin
               r_rem <= w_ge ? w_sub : w_shift[XLEN-1:0];
               r_quo <= {r_quo[XLEN-2:0], w_ge};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state <= StFix;
               end
            end
            StFix: begin
               r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= StOut;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
endmodule

// File: tb/tb_riscv_div_unit.sv
// Scoreboard bench for riscv_div_unit: driver queues expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_riscv_div_unit;
   localparam int unsigned XLEN = 32;
   localparam logic [2:0] FDiv = 3'b100, FDivu = 3'b101, FRem = 3'b110, FRemu = 3'b111;

   typedef struct {
      logic [XLEN-1:0] res;
      int              cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_total;
   int   n_bad;
   exp_t sb[$];

   riscv_div_unit_if #(.XLEN(XLEN)) bus ();

   riscv_div_unit #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 64'(bus.result), 64'(e.res));
            check("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Called at a negedge; drives start for one cycle, returns at the next negedge.
   task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp_res, input int lat, input bit push);
      exp_t e;
      bus.start = 1'b1;
      bus.fun3  = f;
      bus.op_a  = a;
      bus.op_b  = b;
      if (push) begin
         e.res = exp_res;
         e.cyc = cyc + lat;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check(name, 64'(sb.size()), 64'd0);
   endtask

   task automatic count_busy(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (bus.busy) cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int nb;
      cyc       = 0;
      n_total   = 0;
      n_bad     = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.fun3  = 3'b000;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_result", 64'(bus.result), 64'd0);
      @(negedge clk);

      // Normal path, with busy window T+1..T+33.
      issue(FDiv, 32'd20, 32'd6, 32'd3, 34, 1);
      count_busy(40, nb);
      check("busy_cycles", 64'(nb), 64'd33);
      wait_idle("drain_div");
      issue(FRem,  32'd20,       32'd6, 32'd2,        34, 1); wait_idle("drain_rem");
      issue(FDiv,  32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 34, 1); wait_idle("drain_div_neg");
      issue(FRem,  32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, 34, 1); wait_idle("drain_rem_neg");
      issue(FDivu, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 34, 1); wait_idle("drain_divu");
      issue(FRemu, 32'hFFFFFFFF, 32'd2, 32'd1,        34, 1); wait_idle("drain_remu");

      // Special cases finish at T+1 without busy.
      issue(FDiv, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, 1);
      count_busy(5, nb);
      check("busy_div0", 64'(nb), 64'd0);
      wait_idle("drain_div0");
      issue(FRemu, 32'h1234,     32'd0,        32'h1234,     1, 1); wait_idle("drain_remu0");
      issue(FDiv,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1); wait_idle("drain_ovf_div");
      issue(FRem,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 1); wait_idle("drain_ovf_rem");

      // Reset at T+10 discards the in-flight operation.
      issue(FDiv, 32'd100, 32'd7, 32'd0, 0, 0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_result", 64'(bus.result), 64'd0);
      repeat (40) @(negedge clk);
      issue(FDivu, 32'd100, 32'd7, 32'd14, 34, 1); wait_idle("drain_after_rst");

      // Start while busy is ignored; start in the done cycle chains with full latency.
      issue(FDiv, 32'd100, 32'd7, 32'd14, 34, 1);
      repeat (3) @(negedge clk);
      issue(FDiv, 32'd5, 32'd1, 32'd0, 0, 0);
      for (int i = 0; i < 60 && !bus.done; i++) @(negedge clk);
      check("done_seen", 64'(bus.done), 64'd1);
      issue(FDivu, 32'd200, 32'd7, 32'd28, 34, 1);
      wait_idle("drain_b2b");

      // Non-divide funct3 is ignored.
      issue(3'b000, 32'd9, 32'd3, 32'd0, 0, 0);
      count_busy(40, nb);
      check("busy_bad_fun3", 64'(nb), 64'd0);

      check("final_queue", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/riscv_div_unit.md
Name: riscv_div_unit

Overview:
- Iterative radix-2 divider for the RV32M divide/remainder group (DIV, DIVU, REM, REMU).
- Complements the single-cycle ALU multiply group. The ALU hands off divide-class instructions through a start/done handshake and stalls the core while busy is high.
- One result per operation. Operands and function are latched at start.

Parameters:
- XLEN, 32, operand/result width in bits; must be even and >= 8.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; accepted only when busy=0
- fun3  input  3  RV32M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  dividend (rs1 value)
- op_b  input  XLEN  divisor (rs2 value)
- busy  output  1  iterative operation in progress; start ignored
- done  output  1  one-cycle pulse; result valid this cycle
- result  output  XLEN  quotient or remainder; held until next done

Behaviour:
- Reset: on rst=1 at a rising edge, clear all of the following, with rst overriding every other input:
  - busy=0, done=0, result=0
  - FSM forced to IDLE
  - in-flight operation discarded; no done is ever issued for it
- FSM states:
  - IDLE: wait for start.
  - CALC: XLEN iterations.
  - FIX: sign correction and select.
  - OUT: registers result, pulses done.
- Accept:
  - In IDLE or OUT, start=1 with fun3[2]=1 latches fun3, op_a and op_b. Call this cycle T.
  - start with fun3[2]=0 is ignored; no done is issued.
  - start while busy=1 is ignored; inputs are not re-sampled.
- Normal path:
  - Operands are converted to magnitudes for signed ops.
  - busy=1 for cycles T+1 .. T+XLEN+1 (CALC x XLEN, then FIX x 1).
  - done=1 and result valid at cycle T+XLEN+2, with busy=0 in that cycle.
- Back-to-back: a start accepted in the done cycle begins a new operation. Latency is identical.
- Special cases are resolved in the accept cycle. busy stays 0 and done=1 at T+1.
  - Divide by zero (op_b=0):
    - DIV/DIVU quotient = all ones.
    - REM/REMU remainder = op_a.
  - Signed overflow (DIV/REM, op_a=2^(XLEN-1), op_b=all ones):
    - quotient = op_a.
    - remainder = 0.
- Arithmetic:
  - Restoring division. Per CALC cycle: shift {rem, quo} left 1, subtract |divisor| from rem (XLEN+1-bit compare), set quo LSB on no-borrow.
  - Signed: quotient negated iff sign(a) XOR sign(b) and divisor != 0. Remainder takes the sign of the dividend.
  - Rounding is truncation toward zero, so remainder magnitude < |divisor|.
  - Unsigned ops skip sign handling entirely.
- done is high exactly one cycle per accepted request. result changes only in a done cycle or on reset.
- The iteration counter is log2(XLEN)+1 bits and counts XLEN-1 down to 0. The counter never wraps into a further CALC cycle.

Test Plan:
- Reset, then DIV 20/6 at T -> done at T+34, result=3. REM same operands -> result=2. busy high T+1..T+33.
- DIV op_a=0xFFFFFFEC (-20), op_b=6 -> result 0xFFFFFFFD. REM same operands -> 0xFFFFFFFE. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. REMU same operands -> 1.
- DIV 0x1234/0 -> done at T+1, result 0xFFFFFFFF, busy never asserted. REMU 0x1234/0 -> 0x00001234.
- DIV 0x80000000/0xFFFFFFFF -> done at T+1, result 0x80000000. REM same operands -> 0.
- Start DIV 100/7. Assert rst at T+10 -> busy=0, done=0, result=0 next cycle, no done ever follows. A new DIVU 100/7 issued afterward -> 14 with full latency.
- Issue start during busy (op_a=5) -> ignored; original result returned. Issue start in the done cycle -> second done exactly 34 cycles later. Issue start with fun3=000 -> no done, busy stays 0.
